// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ==== uart_rx_pkg : shared types and defaults for the UART RX controller | rev 1.0 ====
package uart_rx_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef struct packed {
    logic                  parity_err;
    logic                  frame_err;
    logic [DATA_W_DEF-1:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_COUNT   = 2'd1,
    T_EXPIRED = 2'd2
  } to_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ==== uart_rx_fifo : synchronous first-word-fall-through FIFO with flush | rev 1.0 ====
module uart_rx_fifo #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (i_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (i_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      // Simultaneous push and pop leaves the level unchanged.
      if (i_wr && !i_rd && level_q != LVL_W'(DEPTH)) level_d = level_q + LVL_W'(1);
      if (!i_wr && i_rd && level_q != '0)            level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ==== uart_rx_ctrl : RX FIFO acceptance, sticky overrun, threshold/timeout IRQs | rev 1.0 ====
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned TO_W   = 16,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_done,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_frame_err,
  input  logic              i_parity_err,
  input  logic              i_rd_en,
  input  logic              i_flush,
  input  logic              i_clr_ovr,
  input  logic [LVL_W-1:0]  i_thresh,
  input  logic [TO_W-1:0]   i_timeout,
  output logic [DATA_W+1:0] o_rd_data,
  output logic              o_rx_empty,
  output logic              o_rx_full,
  output logic [LVL_W-1:0]  o_rx_level,
  output logic              o_overrun_flag,
  output logic              o_irq_thresh,
  output logic              o_irq_timeout,
  output logic              o_irq
);

  logic             full, empty;
  logic [LVL_W-1:0] level, level_nxt;
  logic             rd, wr, ovr_set, activity;
  logic             overrun_q, overrun_d;
  to_state_e        state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]  timeout_last;

  assign rd        = i_rd_en & ~empty;
  assign wr        = i_rx_done & ~i_flush & (~full | rd);
  assign ovr_set   = i_rx_done & full & ~rd & ~i_flush;
  assign activity  = wr | rd;
  assign level_nxt = i_flush ? '0 : level + LVL_W'(wr) - LVL_W'(rd);
  assign timeout_last = i_timeout - TO_W'(1);

  uart_rx_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (wr),
    .i_wdata ({i_parity_err, i_frame_err, i_rx_data}),
    .i_rd    (rd),
    .i_flush (i_flush),
    .o_rdata (o_rd_data),
    .o_full  (full),
    .o_empty (empty),
    .o_level (level)
  );

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_set)        overrun_d = 1'b1;
    else if (i_clr_ovr) overrun_d = 1'b0;
  end

  // level_nxt already folds in flush, so "FIFO empties" covers the flush case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      T_IDLE: begin
        cnt_d = '0;
        if (i_timeout != '0 && level_nxt != '0) state_d = T_COUNT;
      end
      T_COUNT: begin
        if (level_nxt == '0 || i_timeout == '0) begin
          state_d = T_IDLE;
          cnt_d   = '0;
        end else if (activity) begin
          cnt_d = '0;
        end else if (cnt_q == timeout_last) begin
          state_d = T_EXPIRED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      T_EXPIRED: begin
        cnt_d = '0;
        if (level_nxt == '0 || i_timeout == '0) state_d = T_IDLE;
        else if (activity)                      state_d = T_COUNT;
      end
      default: begin
        state_d = T_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_q <= 1'b0;
      state_q   <= T_IDLE;
      cnt_q     <= '0;
    end else begin
      overrun_q <= overrun_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_rx_empty     = empty;
  assign o_rx_full      = full;
  assign o_rx_level     = level;
  assign o_overrun_flag = overrun_q;
  assign o_irq_thresh   = (i_thresh != '0) && (level >= i_thresh);
  assign o_irq_timeout  = (state_q == T_EXPIRED);
  assign o_irq          = o_irq_thresh | o_irq_timeout | o_overrun_flag;

endmodule
`default_nettype wire
